// File: rtl/usb_pkg.sv
// Shared definitions for the nano6502 USB HID path: register map, repeat FSM
// states and the millisecond-to-cycle helper.
package usb_pkg;

   localparam logic [3:0] USB_ADDR_STATUS      = 4'h0;
   localparam logic [3:0] USB_ADDR_KEY_DATA    = 4'h1;
   localparam logic [3:0] USB_ADDR_FIFO_DATA   = 4'h2;
   localparam logic [3:0] USB_ADDR_FIFO_STATUS = 4'h3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DELAY,
      ST_REPEAT
   } rep_state_t;

   function automatic int unsigned ms_to_cyc(input int unsigned clk_hz,
                                             input int unsigned ms);
      return clk_hz / 1000 * ms;
   endfunction

endpackage

// File: rtl/usb_key_fifo.sv
// Small synchronous byte FIFO; head entry is read out of storage through the
// registered read pointer and forced to zero while empty.
module usb_key_fifo #(
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [7:0]                 wr_data,
   input  logic                       pop,
   input  logic                       flush,
   output logic [7:0]                 data,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [7:0]    mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts it.
   assign do_push = push && (!full || do_pop);

   // NOTE: storage has no reset; the head is masked while empty, so stale
   // contents are never observable and the array can map onto plain RAM.
   always_ff @(posedge clk) begin
      if (do_push && !flush) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   assign data = empty ? 8'h00 : mem[rd_ptr];

endmodule

// File: rtl/usb_key_buffer.sv
// Keyboard event buffer: typematic repeat scheduler feeding a small FIFO that
// the CPU drains through register reads.
module usb_key_buffer
   import usb_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ     = 25_000_000,
   parameter int          DEPTH           = 8,
   parameter int unsigned REPEAT_DELAY_MS = 500,
   parameter int unsigned REPEAT_RATE_MS  = 100
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       key_valid_i,
   input  logic [7:0]                 key_char_i,
   input  logic                       key_held_i,
   input  logic                       repeat_en_i,
   input  logic                       pop_i,
   input  logic                       flush_i,
   output logic [7:0]                 data_o,
   output logic                       avail_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o,
   output logic                       overflow_o
);

   localparam int unsigned DLY_CYC   = ms_to_cyc(CLK_FREQ_HZ, REPEAT_DELAY_MS);
   localparam int unsigned RATE_CYC  = ms_to_cyc(CLK_FREQ_HZ, REPEAT_RATE_MS);
   localparam logic [31:0] DLY_LOAD  = 32'(DLY_CYC - 1);
   localparam logic [31:0] RATE_LOAD = 32'(RATE_CYC - 1);

   rep_state_t  state, state_next;
   logic [31:0] cnt, cnt_next;
   logic [7:0]  rep_char, rep_char_next;
   logic        push;
   logic [7:0]  push_char;
   logic        full;
   logic        empty;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         rep_char <= '0;
      end else begin
         state    <= state_next;
         cnt      <= cnt_next;
         rep_char <= rep_char_next;
      end
   end

   // NOTE: every comb output gets a default first so no path infers a latch.
   always_comb begin
      state_next    = state;
      cnt_next      = cnt;
      rep_char_next = rep_char;
      if (flush_i) begin
         state_next = ST_IDLE;
         cnt_next   = '0;
      end else if (state == ST_IDLE) begin
         if (key_valid_i) begin
            state_next    = ST_DELAY;
            cnt_next      = DLY_LOAD;
            rep_char_next = key_char_i;
         end
      end else if (!key_held_i || !repeat_en_i) begin
         state_next = ST_IDLE;
         cnt_next   = '0;
      end else if (key_valid_i) begin
         state_next    = ST_DELAY;
         cnt_next      = DLY_LOAD;
         rep_char_next = key_char_i;
      end else if (cnt == '0) begin
         state_next = ST_REPEAT;
         cnt_next   = RATE_LOAD;
      end else begin
         cnt_next = cnt - 32'd1;
      end
   end

   always_comb begin
      push      = 1'b0;
      push_char = key_char_i;
      if (!flush_i) begin
         if (state == ST_IDLE) begin
            push = key_valid_i;
         end else if (key_held_i && repeat_en_i) begin
            if (key_valid_i) begin
               push = 1'b1;
            end else if (cnt == '0) begin
               push      = 1'b1;
               push_char = rep_char;
            end
         end
      end
   end

   // A push is dropped only when full and no pop frees a slot that cycle.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         overflow_o <= 1'b0;
      end else if (flush_i) begin
         overflow_o <= 1'b0;
      end else if (push && full && !pop_i) begin
         overflow_o <= 1'b1;
      end
   end

   usb_key_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk     (clk_i),
      .rst     (rst_i),
      .push    (push),
      .wr_data (push_char),
      .pop     (pop_i),
      .flush   (flush_i),
      .data    (data_o),
      .count   (count_o),
      .full    (full),
      .empty   (empty)
   );

   assign avail_o = !empty;

endmodule

// File: tb/tb_usb_key_buffer.sv
// Bench for usb_key_buffer: directed key sequences, a queue-based reference
// model compared every cycle, plus literal expectations at key points.
module tb_usb_key_buffer;

   localparam int DEPTH = 4;
   localparam int DLY   = 5;
   localparam int RATE  = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       key_valid = 1'b0;
   logic [7:0] key_char = 8'h00;
   logic       key_held = 1'b0;
   logic       repeat_en = 1'b0;
   logic       pop = 1'b0;
   logic       flush = 1'b0;
   logic [7:0] data;
   logic       avail;
   logic [2:0] count;
   logic       overflow;

   int checks = 0;
   int errors = 0;

   logic [7:0] mq[$];
   logic       m_ovf = 1'b0;
   logic       m_active = 1'b0;
   logic [7:0] m_char = 8'h00;
   int         m_t = 0;
   int         m_t0 = 0;

   usb_key_buffer #(
      .CLK_FREQ_HZ     (1000),
      .DEPTH           (DEPTH),
      .REPEAT_DELAY_MS (5),
      .REPEAT_RATE_MS  (2)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .key_valid_i (key_valid),
      .key_char_i  (key_char),
      .key_held_i  (key_held),
      .repeat_en_i (repeat_en),
      .pop_i       (pop),
      .flush_i     (flush),
      .data_o      (data),
      .avail_o     (avail),
      .count_o     (count),
      .overflow_o  (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: a key-down starts a schedule; repeats fall at t0+DLY+k*RATE
   // while the key stays held and repeat is enabled.
   task automatic model_advance();
      logic       do_push;
      logic [7:0] pc;
      do_push = 1'b0;
      pc      = 8'h00;
      if (flush) begin
         mq.delete();
         m_ovf    = 1'b0;
         m_active = 1'b0;
      end else begin
         if (!m_active) begin
            if (key_valid) begin
               do_push  = 1'b1;
               pc       = key_char;
               m_active = 1'b1;
               m_t0     = m_t;
               m_char   = key_char;
            end
         end else if (!key_held || !repeat_en) begin
            m_active = 1'b0;
         end else if (key_valid) begin
            do_push = 1'b1;
            pc      = key_char;
            m_t0    = m_t;
            m_char  = key_char;
         end else if ((m_t - m_t0) >= DLY && ((m_t - m_t0 - DLY) % RATE) == 0) begin
            do_push = 1'b1;
            pc      = m_char;
         end
         if (pop && mq.size() > 0) void'(mq.pop_front());
         if (do_push) begin
            if (mq.size() < DEPTH) mq.push_back(pc);
            else m_ovf = 1'b1;
         end
      end
      m_t++;
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            mq.delete();
            m_ovf    = 1'b0;
            m_active = 1'b0;
            m_char   = 8'h00;
         end
         check("cmp data_o", 32'(data), 32'(mq.size() > 0 ? mq[0] : 8'h00));
         check("cmp avail_o", 32'(avail), 32'(mq.size() > 0));
         check("cmp count_o", 32'(count), 32'(mq.size()));
         check("cmp overflow_o", 32'(overflow), 32'(m_ovf));
         if (!rst) model_advance();
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
         key_valid = 1'b0;
         pop       = 1'b0;
         flush     = 1'b0;
      end
   endtask

   task automatic press(input logic [7:0] c);
      key_char  = c;
      key_valid = 1'b1;
      tick();
   endtask

   task automatic do_flush();
      flush = 1'b1;
      tick();
   endtask

   task automatic do_pop();
      pop = 1'b1;
      tick();
   endtask

   initial begin
      tick();
      check("reset data", 32'(data), 32'h0);
      check("reset avail", 32'(avail), 32'h0);
      check("reset count", 32'(count), 32'h0);
      check("reset overflow", 32'(overflow), 32'h0);
      rst = 1'b0;
      tick();

      // Basic key
      repeat_en = 1'b1;
      key_held  = 1'b1;
      press(8'h61);
      check("basic data", 32'(data), 32'h61);
      check("basic count", 32'(count), 32'h1);
      tick();
      key_held = 1'b0;
      tick(8);
      check("basic no repeat", 32'(count), 32'h1);
      do_pop();
      check("basic pop data", 32'(data), 32'h0);
      check("basic pop avail", 32'(avail), 32'h0);

      // Auto-repeat to overflow
      do_flush();
      key_held = 1'b1;
      press(8'h41);
      tick(11);
      key_held = 1'b0;
      tick(3);
      check("repeat count", 32'(count), 32'h4);
      check("repeat overflow", 32'(overflow), 32'h1);
      check("repeat data", 32'(data), 32'h41);

      // Key change during DELAY
      do_flush();
      check("flush clears overflow", 32'(overflow), 32'h0);
      key_held = 1'b1;
      press(8'h61);
      tick(2);
      press(8'h62);
      tick(5);
      key_held = 1'b0;
      tick(2);
      check("change count", 32'(count), 32'h3);
      check("change head", 32'(data), 32'h61);
      do_pop();
      check("change 2nd", 32'(data), 32'h62);
      do_pop();
      check("change 3rd", 32'(data), 32'h62);
      do_pop();
      check("change empty", 32'(avail), 32'h0);

      // Simultaneous push and pop while full
      do_flush();
      repeat_en = 1'b0;
      key_held  = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         press(8'(i));
         tick();
      end
      check("full count", 32'(count), 32'h4);
      pop = 1'b1;
      press(8'h35);
      check("pp count", 32'(count), 32'h4);
      check("pp overflow", 32'(overflow), 32'h0);
      check("pp head", 32'(data), 32'h2);
      do_pop();
      check("pp 2nd", 32'(data), 32'h3);
      do_pop();
      check("pp 3rd", 32'(data), 32'h4);
      do_pop();
      check("pp 4th", 32'(data), 32'h35);

      // Repeat disabled, and held dropped exactly at counter expiry
      do_flush();
      key_held = 1'b1;
      press(8'h78);
      tick(8);
      check("disabled count", 32'(count), 32'h1);
      do_flush();
      repeat_en = 1'b1;
      press(8'h79);
      tick(4);
      key_held = 1'b0;
      tick(4);
      check("abort at expiry count", 32'(count), 32'h1);

      // Flush with coincident key while in REPEAT
      do_flush();
      key_held = 1'b1;
      press(8'h7a);
      tick(11);
      check("pre-flush overflow", 32'(overflow), 32'h1);
      key_valid = 1'b1;
      key_char  = 8'h71;
      do_flush();
      check("flush count", 32'(count), 32'h0);
      check("flush overflow", 32'(overflow), 32'h0);
      tick(8);
      check("flush fsm idle", 32'(count), 32'h0);

      // Asynchronous reset mid-REPEAT
      press(8'h72);
      tick(12);
      check("pre-reset count", 32'(count), 32'h4);
      #2;
      rst = 1'b1;
      #1;
      check("async rst data", 32'(data), 32'h0);
      check("async rst avail", 32'(avail), 32'h0);
      check("async rst count", 32'(count), 32'h0);
      check("async rst overflow", 32'(overflow), 32'h0);
      tick(2);
      rst = 1'b0;
      tick(10);
      check("post-reset no push", 32'(count), 32'h0);
      key_held = 1'b0;
      tick(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
